// File: rtl/pc_unit.sv
// Program counter stage: 16-bit PC, operand high-byte latch and HALT state.
// Optional return-address stack enabled by defining PC_CALL_STACK_EN.
module pc_unit #(
  parameter int STACK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        pcoe,
  input  logic [15:0] pcout,
  input  logic        hi_we,
  input  logic [7:0]  databus,
  input  logic        halt,
  input  logic        call,
  input  logic        ret,
  output logic [15:0] pc,
  output logic [7:0]  hibyte,
  output logic        halted,
  output logic        stk_ovf,
  output logic        stk_unf
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HI   = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  hib_q, hib_d;
  logic        ret_act;
  logic [15:0] pop_val;
  logic        act;

  assign act = inc | pcoe | ret_act;

`ifdef PC_CALL_STACK_EN
  localparam int PW = $clog2(STACK_DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(STACK_DEPTH);

  logic [15:0]   stk_q [STACK_DEPTH];
  logic [PW-1:0] sp_q;
  logic [PW:0]   cnt_q;
  logic          ovf_q, unf_q;
  logic          live, push_en, pop_en, pop_empty;

  assign live      = (state_q != S_HALT) && !halt;
  assign ret_act   = ret;
  assign pop_en    = live && ret;
  assign push_en   = live && pcoe && call && !ret;
  assign pop_empty = (cnt_q == '0);
  assign pop_val   = pop_empty ? 16'h0000 : stk_q[sp_q - PW'(1)];

  // sp_q always points at the next free slot; when full it wraps onto the oldest entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= 16'h0000;
    end else if (pop_en) begin
      if (pop_empty) begin
        unf_q <= 1'b1;
      end else begin
        sp_q  <= sp_q - PW'(1);
        cnt_q <= cnt_q - (PW+1)'(1);
      end
    end else if (push_en) begin
      stk_q[sp_q] <= pc_q + 16'd1;
      sp_q        <= sp_q + PW'(1);
      if (cnt_q == CNT_FULL) ovf_q <= 1'b1;
      else                   cnt_q <= cnt_q + (PW+1)'(1);
    end
  end

  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;
`else
  logic unused_stack_ins;

  assign unused_stack_ins = call ^ ret ^ (STACK_DEPTH > 16);
  assign ret_act          = 1'b0;
  assign pop_val          = 16'h0000;
  assign stk_ovf          = 1'b0;
  assign stk_unf          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      pc_q    <= 16'h0000;
      hib_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hib_q   <= hib_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN, S_HI: begin
        if (halt)       state_d = S_HALT;
        else if (hi_we) state_d = S_HI;
        else if (act)   state_d = S_RUN;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RUN;
    endcase
  end

  // HALT wins over everything; otherwise ret > pcoe > inc for the PC
  always_comb begin
    pc_d  = pc_q;
    hib_d = hib_q;
    if (state_q == S_HALT) begin
      hib_d = 8'h00;
    end else if (halt) begin
      hib_d = 8'h00;
    end else begin
      if (ret_act)   pc_d = pop_val;
      else if (pcoe) pc_d = pcout;
      else if (inc)  pc_d = pc_q + 16'd1;
      if (hi_we)     hib_d = databus;
      else if (act)  hib_d = 8'h00;
    end
  end

  always_comb begin
    pc     = pc_q;
    hibyte = hib_q;
    halted = (state_q == S_HALT);
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed cases plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_pc_unit;

  localparam int DEPTH = 4;
`ifdef PC_CALL_STACK_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inc = 1'b0, pcoe = 1'b0, hi_we = 1'b0, halt = 1'b0, call = 1'b0, ret = 1'b0;
  logic [15:0] pcout = 16'h0;
  logic [7:0]  databus = 8'h0;
  logic [15:0] pc;
  logic [7:0]  hibyte;
  logic        halted, stk_ovf, stk_unf;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  pc_unit #(.STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .inc(inc), .pcoe(pcoe), .pcout(pcout),
    .hi_we(hi_we), .databus(databus), .halt(halt), .call(call), .ret(ret),
    .pc(pc), .hibyte(hibyte), .halted(halted), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  // behavioural model
  logic [15:0] m_pc;
  logic [7:0]  m_hib;
  bit          m_halt, m_ovf, m_unf;
  logic [15:0] m_stk[$];

  function automatic void model_reset();
    m_pc = 16'h0; m_hib = 8'h0; m_halt = 0; m_ovf = 0; m_unf = 0;
    m_stk.delete();
  endfunction

  function automatic void model_step();
    logic [15:0] nxt;
    bit any;
    if (m_halt) return;
    if (halt) begin
      m_halt = 1; m_hib = 8'h0;
      return;
    end
    any = inc || pcoe || (STK_EN && ret);
    nxt = m_pc;
    if (STK_EN && ret) begin
      if (m_stk.size() == 0) begin nxt = 16'h0; m_unf = 1; end
      else nxt = m_stk.pop_back();
    end else if (pcoe) begin
      if (STK_EN && call) begin
        if (m_stk.size() == DEPTH) begin void'(m_stk.pop_front()); m_ovf = 1; end
        m_stk.push_back(m_pc + 16'd1);
      end
      nxt = pcout;
    end else if (inc) begin
      nxt = m_pc + 16'd1;
    end
    if (hi_we) m_hib = databus;
    else if (any) m_hib = 8'h0;
    m_pc = nxt;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("hibyte", {8'h0, hibyte}, {8'h0, m_hib});
      chk("halted", {15'h0, halted}, {15'h0, m_halt});
      chk("stk_ovf", {15'h0, stk_ovf}, {15'h0, m_ovf});
      chk("stk_unf", {15'h0, stk_unf}, {15'h0, m_unf});
    end
  end

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset(); else model_step();
    #1;
  endtask

  task automatic drive(input logic i_inc, input logic i_pcoe, input logic [15:0] i_pcout,
                       input logic i_hi, input logic [7:0] i_db, input logic i_halt,
                       input logic i_call, input logic i_ret);
    inc = i_inc; pcoe = i_pcoe; pcout = i_pcout; hi_we = i_hi; databus = i_db;
    halt = i_halt; call = i_call; ret = i_ret;
    tick();
  endtask

  task automatic do_reset();
    rst = 0;
    model_reset();
    drive(0, 0, 16'h0, 0, 8'h0, 0, 0, 0);
    tick();
    rst = 1;
  endtask

  initial begin
    model_reset();
    chk_en = 1'b1;
    do_reset();
    chk("rst pc", pc, 16'h0000);

    // increments from reset
    drive(1, 0, 16'h0, 0, 8'h0, 0, 0, 0); chk("inc1", pc, 16'h0001);
    drive(1, 0, 16'h0, 0, 8'h0, 0, 0, 0); chk("inc2", pc, 16'h0002);
    drive(1, 0, 16'h0, 0, 8'h0, 0, 0, 0); chk("inc3", pc, 16'h0003);
    chk("inc hib", {8'h0, hibyte}, 16'h0000);

    // wrap
    drive(0, 1, 16'hFFFF, 0, 8'h0, 0, 0, 0); chk("load ffff", pc, 16'hFFFF);
    drive(1, 0, 16'h0, 0, 8'h0, 0, 0, 0);    chk("wrap", pc, 16'h0000);

    // two-byte jump
    drive(0, 0, 16'h0, 1, 8'h12, 0, 0, 0);   chk("hi 12", {8'h0, hibyte}, 16'h0012);
    drive(0, 1, 16'h1234, 0, 8'h34, 0, 0, 0); chk("jmp 1234", pc, 16'h1234);
    chk("hib clr", {8'h0, hibyte}, 16'h0000);

    // not-taken jump drops the high byte
    drive(0, 0, 16'h0, 1, 8'hAB, 0, 0, 0);   chk("hi ab", {8'h0, hibyte}, 16'h00AB);
    drive(1, 0, 16'h0, 0, 8'h00, 0, 0, 0);   chk("nt hib", {8'h0, hibyte}, 16'h0000);
    drive(0, 1, 16'h0040, 0, 8'h0, 0, 0, 0); chk("jmp 0040", pc, 16'h0040);

    // HALT beats same-cycle jump
    drive(0, 1, 16'h0010, 0, 8'h0, 0, 0, 0);
    drive(0, 1, 16'h5555, 1, 8'h77, 1, 0, 0); chk("halt pc", pc, 16'h0010);
    chk("halt flag", {15'h0, halted}, 16'h0001);
    for (int i = 0; i < 3; i++) drive(1, 1, 16'h9999, 1, 8'h55, 0, 0, 0);
    chk("halt hold", pc, 16'h0010);
    rst = 0; model_reset(); #1;
    chk("async rst pc", pc, 16'h0000);
    chk("async rst halted", {15'h0, halted}, 16'h0000);
    tick(); rst = 1;

`ifdef PC_CALL_STACK_EN
    drive(0, 1, 16'h0100, 0, 8'h0, 0, 0, 0);
    drive(0, 1, 16'h0200, 0, 8'h0, 0, 1, 0); chk("call", pc, 16'h0200);
    drive(0, 0, 16'h0, 0, 8'h0, 0, 0, 1);    chk("ret", pc, 16'h0101);
    for (int i = 0; i < 5; i++) drive(0, 1, 16'h0300 + 16'(i), 0, 8'h0, 0, 1, 0);
    chk("ovf", {15'h0, stk_ovf}, 16'h0001);
    drive(0, 0, 16'h0, 0, 8'h0, 0, 0, 1);    chk("ret after ovf", pc, 16'h0304);
    do_reset();
    drive(0, 0, 16'h0, 0, 8'h0, 0, 0, 1);    chk("unf pc", pc, 16'h0000);
    chk("unf", {15'h0, stk_unf}, 16'h0001);
    do_reset();
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ((m_halt && $urandom_range(0, 15) == 0) || $urandom_range(0, 499) == 0) begin
        rst = 0; model_reset(); #1;
        chk("mid rst pc", pc, 16'h0000);
        tick(); rst = 1;
      end else begin
        drive($urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0, 16'($urandom),
              $urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 299) == 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
      end
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program counter stage that consumes the jump stage's outputs (`pcoe`, `pcout`) and supplies its `pcin` and high address byte. Holds the 16-bit PC and advances it per fetched byte. Latches the high byte of two-byte jump operands so the jump stage can form `{hibyte, databus}`. Optionally keeps a small return-address stack for call/return.

## Interface

Parameters:
- `STACK_DEPTH`, 4: return-stack entries (power of two, 2–16); used only with `PC_CALL_STACK_EN`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `inc`  in  1  one instruction/operand byte consumed; PC += 1.
- `pcoe`  in  1  jump taken (from jump stage); load `pcout`.
- `pcout`  in  16  jump target (from jump stage).
- `hi_we`  in  1  current `databus` byte is the high half of a two-byte operand.
- `databus`  in  8  shared data bus.
- `halt`  in  1  enter HALT; sticky until reset.
- `call`  in  1  qualifies `pcoe` as a call (macro only; otherwise ignored).
- `ret`  in  1  pop return address into PC (macro only; otherwise ignored).
- `pc`  out  16  current PC, registered; drives jump stage `pcin` and the address bus.
- `hibyte`  out  8  latched operand high byte; 0 when not in HI.
- `halted`  out  1  high in HALT.
- `stk_ovf`  out  1  sticky push-when-full (macro only; tied 0 otherwise).
- `stk_unf`  out  1  sticky pop-when-empty (macro only; tied 0 otherwise).

## Operation

- States:
  - RUN: normal operation.
  - HI: high byte held, waiting for the low-byte cycle.
  - HALT: stopped.
- Per-cycle action priority for the PC (RUN/HI): `ret` > `pcoe` > `inc` > hold.
  - `ret`: pc <= popped entry.
  - `pcoe`: pc <= `pcout`; with `call`, also push pc+1.
  - `inc`: pc <= pc + 1, modulo 2^16. 16'hFFFF wraps to 16'h0000 with no flag.
- RUN transitions:
  - To HI on `hi_we`, with hibyte <= `databus`.
  - Any PC action in the same cycle still applies.
- HI transitions, on the first cycle with `pcoe`, `inc` or `ret`:
  - Return to RUN and clear hibyte to 0.
  - A not-taken jump (`inc` only) must not leak the high byte into later targets.
  - `hi_we` again while in HI overwrites hibyte and stays in HI.
- `hi_we` together with `pcoe`/`inc`/`ret`: the PC action applies, hibyte <= `databus`, next state is HI.
- HALT:
  - Entered from any state on `halt`; HALT wins over all same-cycle actions.
  - PC frozen; hibyte cleared; all inputs ignored; leave only by reset.
- `pc` is a pure register output; no combinational path from any input to `pc` or `hibyte`.

## Timing

- Reset (`rst` low, asynchronous) sets every output and all internal state to zero:
  - `pc`=16'h0000, `hibyte`=8'h00, `halted`=0, `stk_ovf`=0, `stk_unf`=0.
  - State RUN, stack pointer 0.
- Reset deasserts synchronously to `clk` (external synchroniser). First action occurs on the first rising edge with `rst` high.
- Reset mid-operation (HI, HALT, partial stack) discards everything; no state survives.
- Latency: every action is visible on `pc`/`hibyte` one cycle after the sampling edge.
- The jump stage samples `hibyte` in the cycle after `hi_we`. Software must place the low byte on `databus` in that cycle, together with `pcoe`/`inc`.

## Configuration

Macro `PC_CALL_STACK_EN`.

Defined:
- `STACK_DEPTH`-entry LIFO, 16 bits wide.
- Push on `pcoe & call`. Push when full overwrites the oldest entry (circular) and sets `stk_ovf`.
- Pop on `ret`.
  - Normal pop: pc <= top entry.
  - Pop when empty: pc <= 16'h0000 and `stk_unf` is set.
- Same-cycle `ret` and `pcoe & call`: `ret` wins, no push.
- Flags stay sticky until reset.

Undefined:
- No stack storage.
- `call` and `ret` ignored; `stk_ovf`/`stk_unf` tied 0.

## Test plan

- Reset then 3× `inc` -> `pc` = 0000, 0001, 0002, 0003; `hibyte`=00.
- `pc`=FFFF, `inc` -> `pc`=0000, no other output changes.
- `hi_we` with `databus`=12, next cycle `pcoe` with `pcout`=1234 -> `hibyte`=12 for one cycle, then `pc`=1234, `hibyte`=00.
- `hi_we` with `databus`=AB, next cycle `inc` only -> `hibyte` returns to 00, state RUN. A later `pcoe` with `pcout`=0040 loads 0040.
- `halt` asserted together with `pcoe` (`pcout`=5555) at `pc`=0010 -> `pc` stays 0010 and `halted`=1. Subsequent `inc`s are ignored until `rst` low, then all outputs read 0.
- With `PC_CALL_STACK_EN` and depth 4:
  - Call at `pc`=0100 to 0200, then `ret` -> `pc`=0200, then 0101.
  - Five nested calls -> `stk_ovf`=1.
  - `ret` on an empty stack -> `pc`=0000 and `stk_unf`=1.
